// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: streams N four-lane operand groups into a registered MAC,
// feeding the running sum back through c and returning the final result.
module mac_seq_ctrl #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [len_bw-1:0]  cmd_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*bw-1:0]    in_a,
  input  logic [4*bw-1:0]    in_b,
  output logic [bw-1:0]      a0,
  output logic [bw-1:0]      a1,
  output logic [bw-1:0]      a2,
  output logic [bw-1:0]      a3,
  output logic [bw-1:0]      b0,
  output logic [bw-1:0]      b1,
  output logic [bw-1:0]      b2,
  output logic [bw-1:0]      b3,
  output logic [psum_bw-1:0] c,
  input  logic [psum_bw-1:0] mac_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [psum_bw-1:0] res_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [len_bw-1:0]   remain_q, remain_d;
  logic                first_q, first_d;
  logic                issue_q, issue;
  logic [psum_bw-1:0]  psum_q, psum_d;
  logic [psum_bw-1:0]  res_q, res_d;
  logic [4*bw-1:0]     a_l, b_l;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      first_q  <= 1'b0;
      issue_q  <= 1'b0;
      psum_q   <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      first_q  <= first_d;
      issue_q  <= issue;
      psum_q   <= psum_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    first_d  = first_q;
    psum_d   = psum_q;
    res_d    = res_q;
    issue    = 1'b0;
    // MAC inputs reload every cycle, so the sum must be parked here
    if (issue_q) psum_d = mac_out;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          remain_d = cmd_len;
          first_d  = 1'b1;
          if (cmd_len == '0) begin
            psum_d  = '0;
            res_d   = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (in_valid) begin
          issue    = 1'b1;
          remain_d = remain_q - len_bw'(1);
          first_d  = 1'b0;
          if (remain_q == len_bw'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        res_d   = mac_out;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign in_ready  = (state_q == S_RUN);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = res_valid ? res_q : '0;
  assign busy      = (state_q != S_IDLE);

  assign a_l = issue ? in_a : '0;
  assign b_l = issue ? in_b : '0;

  assign a0 = a_l[0*bw +: bw];
  assign a1 = a_l[1*bw +: bw];
  assign a2 = a_l[2*bw +: bw];
  assign a3 = a_l[3*bw +: bw];
  assign b0 = b_l[0*bw +: bw];
  assign b1 = b_l[1*bw +: bw];
  assign b2 = b_l[2*bw +: bw];
  assign b3 = b_l[3*bw +: bw];

  assign c = (issue && first_q) ? '0 :
             (issue_q ? mac_out : psum_q);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: table-driven bench with a behavioural MAC and a
// result scoreboard for the mac_seq_ctrl sequencer.
module tb_mac_seq_ctrl;
  localparam int BW = 4;
  localparam int PW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4*BW-1:0] in_a = '0;
  logic [4*BW-1:0] in_b = '0;
  logic [BW-1:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic [PW-1:0] c;
  logic [PW-1:0] mac_out;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [PW-1:0] res_data;
  logic          busy;

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  logic [PW-1:0] exp_q[$];

  typedef struct {
    int          n;
    logic [15:0] a;
    logic [15:0] b;
    int          gap1;
    int          gap2;
    int          hold;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  mac_seq_ctrl #(.bw(BW), .psum_bw(PW), .len_bw(LW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .c(c), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered 4-lane MAC: result of cycle t visible in cycle t+1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mac_out <= '0;
    else mac_out <= c + PW'(a0) * PW'(b0) + PW'(a1) * PW'(b1)
                      + PW'(a2) * PW'(b2) + PW'(a3) * PW'(b3);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] dot(input logic [15:0] a,
                                        input logic [15:0] b);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < 4; i++)
      s += PW'(a[i*BW +: BW]) * PW'(b[i*BW +: BW]);
    return s;
  endfunction

  task automatic run_cmd(input vec_t v);
    logic [PW-1:0] acc;
    logic [PW-1:0] rd;
    logic [PW-1:0] ex;
    int t0;
    int lim;
    acc = '0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len = LW'(v.n);
    #1 chk("cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    t0 = int'(cyc);
    cmd_valid = 1'b0;
    for (int g = 0; g < v.n; g++) begin
      int gap;
      gap = (g == 1) ? v.gap1 : ((g == 2) ? v.gap2 : 0);
      for (int s = 0; s < gap; s++) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        #1 chk("stall_lanes", {a3, a2, a1, a0, b3, b2, b1, b0}, 0);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_a = v.a;
      in_b = v.b;
      #1;
      chk("in_ready", 32'(in_ready), 1);
      chk("lanes", {a3, a2, a1, a0, b3, b2, b1, b0}, {v.a, v.b});
      acc += dot(v.a, v.b);
    end
    exp_q.push_back(acc);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    lim = 0;
    while (!res_valid && lim < 1000) begin
      @(negedge clk);
      #1;
      lim++;
    end
    if (!res_valid) begin
      chk("res_timeout", 0, 1);
      return;
    end
    chk("latency", int'(cyc) - t0 + 1, v.lat);
    rd = res_data;
    for (int h = 0; h < v.hold; h++) begin
      chk("hold", {res_valid, cmd_ready, res_data}, {1'b1, 1'b0, rd});
      @(negedge clk);
      #1;
    end
    res_ready = 1'b1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 0, 1);
      ex = '0;
    end else begin
      ex = exp_q.pop_front();
    end
    chk("res_valid", 32'(res_valid), 1);
    chk("res_data", 32'(res_data), 32'(ex));
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    #1 chk("idle_after", {busy, res_valid, cmd_ready}, 3'b001);
  endtask

  initial begin
    vecs[0] = '{n: 1, a: 16'h4321, b: 16'h1111,
                gap1: 0, gap2: 0, hold: 0, lat: 3};
    vecs[1] = '{n: 3, a: 16'h1111, b: 16'h2222,
                gap1: 0, gap2: 0, hold: 0, lat: 5};
    vecs[2] = '{n: 3, a: 16'h1111, b: 16'h2222,
                gap1: 2, gap2: 3, hold: 0, lat: 10};
    vecs[3] = '{n: 3, a: 16'h1111, b: 16'h2222,
                gap1: 0, gap2: 0, hold: 4, lat: 5};
    vecs[4] = '{n: 0, a: 16'h0000, b: 16'h0000,
                gap1: 0, gap2: 0, hold: 0, lat: 1};
    vecs[5] = '{n: 2, a: 16'h9A3F, b: 16'hF1C7,
                gap1: 1, gap2: 0, hold: 2, lat: 5};
    vecs[6] = '{n: 255, a: 16'hFFFF, b: 16'hFFFF,
                gap1: 0, gap2: 0, hold: 0, lat: 257};

    #12;
    chk("rst_ctrl", {cmd_ready, in_ready, res_valid, busy}, 0);
    chk("rst_data", {res_data, c}, 0);
    chk("rst_lanes", {a3, a2, a1, a0, b3, b2, b1, b0}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("idle_ready", 32'(cmd_ready), 1);

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // abort a 4-group command after two issues
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len = 8'd4;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = 16'h7777;
      in_b = 16'h5555;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_ctrl", {cmd_ready, in_ready, res_valid, busy}, 0);
    chk("mid_rst_data", {res_data, c}, 0);
    chk("mid_rst_lanes", {a3, a2, a1, a0, b3, b2, b1, b0}, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("no_stale_res", {res_valid, busy, cmd_ready}, 3'b001);
    end
    run_cmd(vecs[0]);
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
